// File: rtl/fft_wn_gen.sv
// Streaming twiddle-factor generator for a radix-2 DIT FFT.
// Emits W_N^e for every butterfly of every stage over a valid/ready port.
module fft_wn_gen #(
  parameter int unsigned FFT_LOG2  = 6,
  parameter int unsigned FFT_WN_WD = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_inv,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_out_vld,
  input  logic                   i_out_rdy,
  output logic [FFT_WN_WD-1:0]   o_out_re,
  output logic [FFT_WN_WD-1:0]   o_out_im,
  output logic [3:0]             o_out_stg,
  output logic [FFT_LOG2-2:0]    o_out_bfy,
  output logic                   o_out_last
);

  localparam int unsigned N   = 1 << FFT_LOG2;
  localparam int unsigned Q   = N / 4;
  localparam int unsigned B_W = FFT_LOG2 - 1;
  localparam int unsigned A_W = FFT_LOG2 - 1;
  localparam int unsigned M_W = FFT_WN_WD - 1;
  localparam longint      PI_Q30 = 64'sd3373259426;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Elaboration-time round(2^(WD-2) * sin(2*pi*k/N)) using a Q30 Taylor series.
  function automatic logic [M_W-1:0] tab_val(input int unsigned k);
    longint x, x2, term, acc, v;
    x    = (PI_Q30 * longint'(k)) / longint'(2 * Q);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n < 14; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    v = (acc * (longint'(1) << (FFT_WN_WD - 2)) + (longint'(1) << 29)) >>> 30;
    return M_W'(v);
  endfunction

  logic [M_W-1:0] w_rom [0:Q];
  for (genvar k = 0; k <= Q; k++) begin : g_rom
    localparam logic [M_W-1:0] TV = tab_val(k);
    assign w_rom[k] = TV;
  end

  logic [1:0]     r_state, w_state_nxt;
  logic [3:0]     r_s;
  logic [B_W-1:0] r_b;
  logic           r_inv, r_busy, r_done;

  logic           r_p1_vld, r_p1_q, r_p1_last;
  logic [B_W-1:0] r_p1_e, r_p1_b;
  logic [3:0]     r_p1_s;

  logic                 r_out_vld, r_out_last;
  logic [FFT_WN_WD-1:0] r_out_re, r_out_im;
  logic [3:0]           r_out_stg;
  logic [B_W-1:0]       r_out_bfy;

  logic                 w_p2_adv, w_p1_adv, w_start_ok, w_issue, w_issue_last, w_last_hs;
  logic [B_W-1:0]       w_e;
  logic                 w_q;
  logic [A_W-1:0]       w_ra, w_ia;
  logic [FFT_WN_WD-1:0] w_re_mag, w_im_mag, w_re, w_im;

  assign w_p2_adv     = !r_out_vld | i_out_rdy;
  assign w_p1_adv     = !r_p1_vld | w_p2_adv;
  // A start in the done cycle is held off so the finished sequence is fully retired.
  assign w_start_ok   = (r_state == S_IDLE) & i_start & !r_done;
  assign w_issue      = w_start_ok | ((r_state == S_RUN) & w_p1_adv);
  assign w_issue_last = (r_s == 4'(FFT_LOG2 - 1)) & (r_b == {B_W{1'b1}});
  assign w_last_hs    = r_out_vld & i_out_rdy & r_out_last;

  assign w_e = B_W'((32'(r_b) & ((32'd1 << r_s) - 32'd1)) << (32'(FFT_LOG2 - 1) - 32'(r_s)));
  assign w_q = 32'(w_e) > Q;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_issue_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Issue counters sit at zero while idle, so the start cycle issues (0,0) directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_b    <= '0;
      r_inv  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_issue) begin
        if (w_issue_last) begin
          r_s <= '0;
          r_b <= '0;
        end else if (r_b == {B_W{1'b1}}) begin
          r_b <= '0;
          r_s <= r_s + 4'd1;
        end else begin
          r_b <= r_b + B_W'(1);
        end
      end
      if (w_start_ok) r_inv <= i_inv;
      if (w_start_ok)     r_busy <= 1'b1;
      else if (w_last_hs) r_busy <= 1'b0;
      r_done <= w_last_hs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld  <= 1'b0;
      r_p1_e    <= '0;
      r_p1_q    <= 1'b0;
      r_p1_s    <= '0;
      r_p1_b    <= '0;
      r_p1_last <= 1'b0;
    end else if (w_p1_adv) begin
      r_p1_vld <= w_issue;
      if (w_issue) begin
        r_p1_e    <= w_e;
        r_p1_q    <= w_q;
        r_p1_s    <= r_s;
        r_p1_b    <= r_b;
        r_p1_last <= w_issue_last;
      end
    end
  end

  // Quadrant folding: both magnitudes come from the same quarter-wave table.
  assign w_ra     = r_p1_q ? A_W'(32'(r_p1_e) - Q) : A_W'(Q - 32'(r_p1_e));
  assign w_ia     = r_p1_q ? A_W'(2 * Q - 32'(r_p1_e)) : r_p1_e;
  assign w_re_mag = {1'b0, w_rom[w_ra]};
  assign w_im_mag = {1'b0, w_rom[w_ia]};
  assign w_re     = r_p1_q ? -w_re_mag : w_re_mag;
  assign w_im     = r_inv ? w_im_mag : -w_im_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_re   <= '0;
      r_out_im   <= '0;
      r_out_stg  <= '0;
      r_out_bfy  <= '0;
      r_out_last <= 1'b0;
    end else if (w_p2_adv) begin
      r_out_vld <= r_p1_vld;
      if (r_p1_vld) begin
        r_out_re   <= w_re;
        r_out_im   <= w_im;
        r_out_stg  <= r_p1_s;
        r_out_bfy  <= r_p1_b;
        r_out_last <= r_p1_last;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_out_vld  = r_out_vld;
  assign o_out_re   = r_out_re;
  assign o_out_im   = r_out_im;
  assign o_out_stg  = r_out_stg;
  assign o_out_bfy  = r_out_bfy;
  assign o_out_last = r_out_last;

endmodule

// File: doc/fft_wn_gen.md
# fft_wn_gen

Sequential twiddle-factor generator for a radix-2 DIT FFT of size N = 2^FFT_LOG2. After a start pulse it streams the twiddle W_N^e for every butterfly of every stage, in processing order, one per accepted handshake. Values come from a quarter-wave magnitude table with quadrant folding. It sits between the FFT controller and the butterfly datapath and replaces the fixed 64-point combinational twiddle lookup. It adds size/width parameters, a valid/ready output, back-pressure and an inverse-FFT (conjugate) mode.

## Interface
- FFT_LOG2, 6, log2 of FFT size N; legal range 3..12
- FFT_WN_WD, 10, twiddle width, two's complement; unity = 2^(FFT_WN_WD-2)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a full twiddle sequence; honoured only when idle
- inv  in  1  inverse mode, sampled with an accepted start; 1 = output conj(W)
- busy  out  1  high from accepted start until the last output handshake
- done  out  1  one-cycle pulse in the cycle after the last output handshake
- out_vld  out  1  output word valid
- out_rdy  in  1  downstream accepts the word when out_vld & out_rdy
- out_re  out  FFT_WN_WD  real part of twiddle
- out_im  out  FFT_WN_WD  imaginary part of twiddle
- out_stg  out  4  stage index s of this word
- out_bfy  out  FFT_LOG2-1  butterfly index b within the stage
- out_last  out  1  marks the final word of the sequence

## Operation
- Q = N/4. Table T[k], k = 0..Q, unsigned FFT_WN_WD-1 bits: T[k] = round(2^(FFT_WN_WD-2)·sin(2πk/N)).
- Defaults give T = 0,25,50,74,98,121,142,162,181,198,213,226,237,245,251,255,256. The table is a case ROM.
- Sequence: s = 0..FFT_LOG2-1 outer loop, b = 0..N/2-1 inner loop, LOG2·N/2 words total.
- Exponent e = (b mod 2^s) · 2^(FFT_LOG2-1-s), so e is always in [0, N/2).
- Folding, forward mode:
  - e ≤ Q: re = +T[Q-e], im = −T[e]
  - e > Q: re = −T[e-Q], im = −T[2Q-e]
- Negation is the FFT_WN_WD-bit two's complement of the zero-extended magnitude. −0 must produce 0.
- Inverse mode: im is negated again, giving conj(W); re is unchanged.
- FSM states:
  - IDLE: start → RUN; clears counters and latches inv.
  - RUN: issue address counters advance on each pipeline advance. After the last address is issued → DRAIN.
  - DRAIN: after the last output handshake → IDLE, and done pulses.
- start during RUN/DRAIN is ignored; the latched inv is not modified.
- Pipeline, 2 stages:
  - P1 registers e, quadrant flag, s and b.
  - P2 registers the ROM read, the negations and the out_* fields.
- Each stage advances when it is empty or when the next stage advances. P2 advances when !out_vld | out_rdy.
- No word is dropped or duplicated under any out_rdy pattern.

## Timing
- Reset: busy=0, done=0, out_vld=0, out_re=0, out_im=0, out_stg=0, out_bfy=0, out_last=0, FSM=IDLE, inv latch=0.
- Start seen at edge t (out_rdy=1) → busy=1 from t+1, first word out_vld=1 from t+2. Latency is 2 cycles.
- With out_rdy held high: one word per cycle, no bubbles. Last word at t+1+LOG2·N/2.
- While out_vld=1 and out_rdy=0: all out_* hold stable.
- out_last=1 only on the word with s=FFT_LOG2-1, b=N/2-1.
- done: 1 cycle, in the cycle after the out_last handshake. busy falls in that same cycle.
- start coincident with done is ignored; it is accepted the next cycle.
- rst asserted mid-sequence: immediate return to reset values. Pending words are discarded; a new start is required.

## Test plan
- Defaults, forward, out_rdy=1: start → 192 words. Stage 0: all (256,0). Stage 5, b=8 (e=8): (181,−181). b=16 (e=16): (0,−256). b=24 (e=24): (−181,−181). done one cycle after word 192.
- Inverse mode, same run: every im negated vs forward; stage 5, b=24 gives (−181,+181). e=0 gives im=0, not −0 overflow.
- Back-pressure: pseudo-random out_rdy at 30% duty. Accepted stream identical to the scenario 1 stream; out_* stable during stalls; count stays 192.
- Generic: FFT_LOG2=4, FFT_WN_WD=12, so T[0..4] = 0,392,724,946,1024. Stage 3, b=2 (e=2): (724,−724). 32 words total.
- start during busy, and rst asserted at word 50: start is ignored (inv unchanged). After rst all outputs return to 0. A fresh start restarts at s=0, b=0.
